// File: rtl/led_bar_meter.sv
// LED bar-graph meter: saturating level capture, fast-attack/slow-decay smoothing,
// peak-hold marker, and a registered bar or dot LED map with optional peak overlay.
module led_bar_meter #(
    parameter int unsigned N_LEDS      = 16,
    parameter int unsigned LEVEL_W     = 5,
    parameter int unsigned HOLD_TICKS  = 8,
    parameter int unsigned DECAY_TICKS = 4,
    localparam int unsigned CW         = $clog2(N_LEDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEVEL_W-1:0] level,
    input  logic              level_valid,
    input  logic              tick,
    input  logic              mode,
    input  logic              peak_en,
    output logic [N_LEDS-1:0] led,
    output logic [CW-1:0]     peak_level
);

    localparam int unsigned DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int unsigned SW = (LEVEL_W > CW) ? LEVEL_W : CW;

    logic [CW-1:0] tgt, disp, peak;
    logic [CW-1:0] tgt_n, disp_n, peak_n;
    logic [DW-1:0] dcnt, pdcnt, dcnt_n, pdcnt_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [CW-1:0] sat_c;
    logic [N_LEDS-1:0] led_n;

    // Clamp the raw sample to full scale
    always_comb begin
        if (SW'(level) > SW'(N_LEDS)) sat_c = CW'(N_LEDS);
        else                          sat_c = CW'(level);
    end

    // Next state: attack/decay of disp, capture/hold/decay of peak, peak floor at disp
    always_comb begin
        tgt_n   = tgt;
        disp_n  = disp;
        dcnt_n  = dcnt;
        peak_n  = peak;
        hcnt_n  = hcnt;
        pdcnt_n = pdcnt;

        if (level_valid) tgt_n = sat_c;

        if (level_valid && (sat_c > disp)) begin
            disp_n = sat_c;
            dcnt_n = '0;
        end else if (tick) begin
            if (disp > tgt_n) begin
                if (dcnt == DW'(DECAY_TICKS - 1)) begin
                    disp_n = disp - CW'(1);
                    dcnt_n = '0;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end else begin
                dcnt_n = '0;
            end
        end

        if (level_valid && (sat_c >= peak)) begin
            peak_n  = sat_c;
            hcnt_n  = '0;
            pdcnt_n = '0;
        end else if (tick) begin
            if (hcnt < HW'(HOLD_TICKS)) begin
                hcnt_n = hcnt + HW'(1);
            end else if (peak > disp_n) begin
                if (pdcnt == DW'(DECAY_TICKS - 1)) begin
                    peak_n  = peak - CW'(1);
                    pdcnt_n = '0;
                end else begin
                    pdcnt_n = pdcnt + DW'(1);
                end
            end else begin
                pdcnt_n = '0;
            end
        end

        if (peak_n < disp_n) peak_n = disp_n;
    end

    // LED map from the registered levels
    always_comb begin
        led_n = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (mode) led_n[i] = (disp != '0) && (CW'(i) == disp - CW'(1));
            else      led_n[i] = (CW'(i) < disp);
            if (peak_en && (peak != '0) && (CW'(i) == peak - CW'(1))) led_n[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt   <= '0;
            disp  <= '0;
            peak  <= '0;
            dcnt  <= '0;
            pdcnt <= '0;
            hcnt  <= '0;
            led   <= '0;
        end else begin
            tgt   <= tgt_n;
            disp  <= disp_n;
            peak  <= peak_n;
            dcnt  <= dcnt_n;
            pdcnt <= pdcnt_n;
            hcnt  <= hcnt_n;
            led   <= led_n;
        end
    end

    assign peak_level = peak;

endmodule

// File: tb/tb_led_bar_meter.sv
// Bench for led_bar_meter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an integer reference model.
module tb_led_bar_meter;

    localparam int N  = 16;
    localparam int LW = 5;
    localparam int HT = 3;
    localparam int DT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] level;
    logic          level_valid;
    logic          tick;
    logic          mode;
    logic          peak_en;
    logic [N-1:0]  led;
    logic [4:0]    peak_level;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state (plain integers)
    int md = 0, mt = 0, mp = 0;          // displayed, target, peak levels
    int dticks = 0, pticks = 0, held = 0;
    int mled = 0;

    led_bar_meter #(
        .N_LEDS(N), .LEVEL_W(LW), .HOLD_TICKS(HT), .DECAY_TICKS(DT)
    ) dut (
        .clk(clk), .rst(rst), .level(level), .level_valid(level_valid),
        .tick(tick), .mode(mode), .peak_en(peak_en),
        .led(led), .peak_level(peak_level)
    );

    always #5 clk = ~clk;

    function automatic int led_of(int d, int p, logic m, logic pe);
        int r = 0;
        for (int i = 0; i < N; i++)
            if (m ? (i == d - 1) : (i < d)) r = r | (1 << i);
        if (pe && p > 0) r = r | (1 << (p - 1));
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: integer levels and tick counts derived from the behavioural rules
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md = 0; mt = 0; mp = 0; dticks = 0; pticks = 0; held = 0; mled = 0;
        end else begin
            int s;
            bit att, cap;
            mled = led_of(md, mp, mode, peak_en);
            s    = (int'(level) > N) ? N : int'(level);
            att  = level_valid && (s > md);
            cap  = level_valid && (s >= mp);
            if (level_valid) mt = s;
            if (att) begin
                md = s; dticks = 0;
            end else if (tick) begin
                if (md > mt) begin
                    dticks++;
                    if (dticks == DT) begin md--; dticks = 0; end
                end else dticks = 0;
            end
            if (cap) begin
                mp = s; held = 0; pticks = 0;
            end else if (tick) begin
                if (held < HT) held++;
                else if (mp > md) begin
                    pticks++;
                    if (pticks == DT) begin mp--; pticks = 0; end
                end else pticks = 0;
            end
            if (mp < md) mp = md;
        end
    end

    // Every-cycle comparison, settled after the active edge
    always @(posedge clk) begin
        #1;
        chk("led", int'(led), mled);
        chk("peak_level", int'(peak_level), mp);
        chk("peak_ge_disp", int'(int'(peak_level) >= md), 1);
    end

    task automatic cyc(input logic v, input logic [LW-1:0] l, input logic t);
        level_valid = v; level = l; tick = t;
        @(negedge clk);
        level_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_led", int'(led), 0);
        chk("rst_peak", int'(peak_level), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; level = '0; level_valid = 1'b0; tick = 1'b0;
        mode = 1'b0; peak_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_led", int'(led), 0);
        chk("init_peak", int'(peak_level), 0);
        rst = 1'b0;

        // bar display of a small level, then saturation
        cyc(1, 5'd5, 0); cyc(0, 0, 0);
        chk("t1_led5", int'(led), 'h001F);
        cyc(1, 5'd31, 0); cyc(0, 0, 0);
        chk("t1_led_full", int'(led), 'hFFFF);
        chk("t1_peak_full", int'(peak_level), 16);

        // decay of disp and hold then decay of peak
        do_reset();
        cyc(1, 5'd10, 0); cyc(1, 5'd2, 0);
        repeat (4) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("t2_led", int'(led), 'h00FF);
        chk("t2_peak_held", int'(peak_level), 10);
        cyc(0, 0, 1);
        chk("t2_peak_step", int'(peak_level), 9);

        // dot mode with peak overlay, no ticks so disp stays at 6
        do_reset();
        mode = 1'b1; peak_en = 1'b1;
        cyc(1, 5'd6, 0); cyc(1, 5'd3, 0); cyc(0, 0, 0);
        chk("t3_dot", int'(led), 'h0020);
        cyc(1, 5'd0, 0); cyc(0, 0, 0);
        chk("t3_dot_zero_lvl", int'(led), 'h0020);
        repeat (2) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("t3_dot_decayed", int'(led), 'h0030);

        // attack coincident with tick
        do_reset();
        mode = 1'b0; peak_en = 1'b0;
        cyc(1, 5'd8, 0); cyc(1, 5'd12, 1); cyc(0, 0, 0);
        chk("t4_led", int'(led), 'h0FFF);
        chk("t4_peak", int'(peak_level), 12);

        // reset mid-decay, then fresh sample
        cyc(1, 5'd0, 0);
        repeat (9) cyc(0, 0, 1);
        do_reset();
        cyc(1, 5'd4, 0); cyc(0, 0, 0);
        chk("t5_led", int'(led), 'h000F);

        // full-scale fall with tick held high
        do_reset();
        cyc(1, 5'd16, 0); cyc(1, 5'd0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 1);
            if (i == 31) chk("t6_led_last", int'(led), 'h0001);
            if (i == 32) chk("t6_led_zero", int'(led), 0);
            if (i == 33) chk("t6_peak_one", int'(peak_level), 1);
            if (i == 34) chk("t6_peak_zero", int'(peak_level), 0);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else begin
                if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
                if ($urandom_range(0, 15) == 0) peak_en = 1'($urandom);
                cyc(1'($urandom_range(0, 3) == 0), LW'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
